// File: rtl/bank_pkg.sv
// Shared opcode, cacheline-state and FSM definitions for the bank SRAM controller.
package bank_pkg;

    localparam int DATA_W = 128;

    localparam logic [1:0] OP_WRITE     = 2'd0;
    localparam logic [1:0] OP_READ      = 2'd1;
    localparam logic [1:0] OP_LINEFILL  = 2'd2;
    localparam logic [1:0] OP_WRITEBACK = 2'd3;

    localparam logic [1:0] CL_INVALID   = 2'b00;
    localparam logic [1:0] CL_CLEAN     = 2'b01;
    localparam logic [1:0] CL_DIRTY     = 2'b10;
    localparam logic [1:0] CL_CLEAN_ALT = 2'b11;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_WBUF_RD,
        ST_WR,
        ST_RD_REQ,
        ST_RD_CAP,
        ST_LF_WR0,
        ST_LF_WR1,
        ST_WB_RD0,
        ST_WB_RD1,
        ST_WB_CAP,
        ST_WB_SEND,
        ST_RSP
    } state_e;

    // Only the explicit dirty code protects a half from being overwritten;
    // the spare code 11 behaves like clean.
    function automatic logic is_dirty(input logic [1:0] st);
        logic dirty;
        case (st)
            CL_DIRTY:                           dirty = 1'b1;
            CL_INVALID, CL_CLEAN, CL_CLEAN_ALT: dirty = 1'b0;
            default:                            dirty = 1'b0;
        endcase
        return dirty;
    endfunction

endpackage

// File: rtl/bank_sram_ctrl.sv
// Per-bank SRAM controller: executes one issue-queue request at a time
// (write, read, read with linefill, write-back) against the 128-bit data SRAM.
module bank_sram_ctrl
    import bank_pkg::*;
#(
    parameter int WBUF_ID_W = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,

    input  logic                  iq_sc_valid_i,
    output logic                  iq_sc_ready_o,
    input  logic [1:0]            iq_sc_channel_id_i,
    input  logic [2:0]            iq_sc_opcode_i,
    input  logic [6:0]            iq_sc_set_way_offset_i,
    input  logic [WBUF_ID_W-1:0]  iq_sc_wbuffer_id_i,
    input  logic [2:0]            iq_sc_xbar_rob_num_i,
    input  logic [1:0]            iq_sc_cacheline_state_offset0_i,
    input  logic [1:0]            iq_sc_cacheline_state_offset1_i,
    input  logic [DATA_W-1:0]     iq_sc_linefill_data_offset0_i,
    input  logic [DATA_W-1:0]     iq_sc_linefill_data_offset1_i,

    output logic [WBUF_ID_W-1:0]  wbuf_raddr_o,
    input  logic [DATA_W-1:0]     wbuf_rdata_i,

    output logic                  sram_cs_o,
    output logic                  sram_we_o,
    output logic [6:0]            sram_addr_o,
    output logic [DATA_W-1:0]     sram_wdata_o,
    input  logic [DATA_W-1:0]     sram_rdata_i,

    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [1:0]            rsp_channel_id_o,
    output logic [2:0]            rsp_rob_num_o,
    output logic                  rsp_is_write_o,
    output logic [DATA_W-1:0]     rsp_data_o,

    output logic                  wb_valid_o,
    input  logic                  wb_ready_i,
    output logic [5:0]            wb_line_o,
    output logic [2*DATA_W-1:0]   wb_data_o
);

    state_e                 state_q;
    state_e                 state_d;

    logic [1:0]             chan_q;
    logic [1:0]             op_q;
    logic [6:0]             swo_q;
    logic [WBUF_ID_W-1:0]   wbid_q;
    logic [2:0]             rob_q;
    logic [1:0]             st0_q;
    logic [1:0]             st1_q;
    logic [DATA_W-1:0]      lf0_q;
    logic [DATA_W-1:0]      lf1_q;
    logic [DATA_W-1:0]      rsp_data_q;
    logic [DATA_W-1:0]      wb_h0_q;
    logic [DATA_W-1:0]      wb_h1_q;

    logic [5:0]             line;
    logic                   req_dirty;
    logic                   unused_opcode_msb;

    assign line              = swo_q[6:1];
    // A dirty requested half keeps the SRAM copy, which must then be read back.
    assign req_dirty         = is_dirty(swo_q[0] ? st1_q : st0_q);
    // Opcode bit 2 carries no meaning for this block.
    assign unused_opcode_msb = iq_sc_opcode_i[2];

    // State register; reset aborts any operation in flight.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Request capture on accept and data capture from the SRAM along each path.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            chan_q     <= '0;
            op_q       <= '0;
            swo_q      <= '0;
            wbid_q     <= '0;
            rob_q      <= '0;
            st0_q      <= '0;
            st1_q      <= '0;
            lf0_q      <= '0;
            lf1_q      <= '0;
            rsp_data_q <= '0;
            wb_h0_q    <= '0;
            wb_h1_q    <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (iq_sc_valid_i) begin
                        chan_q <= iq_sc_channel_id_i;
                        op_q   <= iq_sc_opcode_i[1:0];
                        swo_q  <= iq_sc_set_way_offset_i;
                        wbid_q <= iq_sc_wbuffer_id_i;
                        rob_q  <= iq_sc_xbar_rob_num_i;
                        st0_q  <= iq_sc_cacheline_state_offset0_i;
                        st1_q  <= iq_sc_cacheline_state_offset1_i;
                        lf0_q  <= iq_sc_linefill_data_offset0_i;
                        lf1_q  <= iq_sc_linefill_data_offset1_i;
                    end
                end
                ST_WR:     rsp_data_q <= '0;
                ST_RD_CAP: rsp_data_q <= sram_rdata_i;
                ST_LF_WR1: begin
                    if (!req_dirty) begin
                        rsp_data_q <= swo_q[0] ? lf1_q : lf0_q;
                    end
                end
                ST_WB_RD1: wb_h0_q <= sram_rdata_i;
                ST_WB_CAP: wb_h1_q <= sram_rdata_i;
                default: ;
            endcase
        end
    end

    // Next-state and output decode; every output is idle-low outside its own state.
    always_comb begin
        state_d          = state_q;
        iq_sc_ready_o    = 1'b0;
        wbuf_raddr_o     = '0;
        sram_cs_o        = 1'b0;
        sram_we_o        = 1'b0;
        sram_addr_o      = '0;
        sram_wdata_o     = '0;
        rsp_valid_o      = 1'b0;
        rsp_channel_id_o = '0;
        rsp_rob_num_o    = '0;
        rsp_is_write_o   = 1'b0;
        rsp_data_o       = '0;
        wb_valid_o       = 1'b0;
        wb_line_o        = '0;
        wb_data_o        = '0;

        case (state_q)
            ST_IDLE: begin
                iq_sc_ready_o = 1'b1;
                if (iq_sc_valid_i) begin
                    case (iq_sc_opcode_i[1:0])
                        OP_WRITE:     state_d = ST_WBUF_RD;
                        OP_READ:      state_d = ST_RD_REQ;
                        OP_LINEFILL:  state_d = ST_LF_WR0;
                        OP_WRITEBACK: state_d = ST_WB_RD0;
                        default:      state_d = ST_IDLE;
                    endcase
                end
            end
            ST_WBUF_RD: begin
                wbuf_raddr_o = wbid_q;
                state_d      = ST_WR;
            end
            ST_WR: begin
                sram_cs_o    = 1'b1;
                sram_we_o    = 1'b1;
                sram_addr_o  = swo_q;
                sram_wdata_o = wbuf_rdata_i;
                state_d      = ST_RSP;
            end
            ST_RD_REQ: begin
                sram_cs_o   = 1'b1;
                sram_addr_o = swo_q;
                state_d     = ST_RD_CAP;
            end
            ST_RD_CAP: begin
                state_d = ST_RSP;
            end
            ST_LF_WR0: begin
                if (!is_dirty(st0_q)) begin
                    sram_cs_o    = 1'b1;
                    sram_we_o    = 1'b1;
                    sram_addr_o  = {line, 1'b0};
                    sram_wdata_o = lf0_q;
                end
                state_d = ST_LF_WR1;
            end
            ST_LF_WR1: begin
                if (!is_dirty(st1_q)) begin
                    sram_cs_o    = 1'b1;
                    sram_we_o    = 1'b1;
                    sram_addr_o  = {line, 1'b1};
                    sram_wdata_o = lf1_q;
                end
                state_d = req_dirty ? ST_RD_REQ : ST_RSP;
            end
            ST_WB_RD0: begin
                sram_cs_o   = 1'b1;
                sram_addr_o = {line, 1'b0};
                state_d     = ST_WB_RD1;
            end
            ST_WB_RD1: begin
                sram_cs_o   = 1'b1;
                sram_addr_o = {line, 1'b1};
                state_d     = ST_WB_CAP;
            end
            ST_WB_CAP: begin
                state_d = ST_WB_SEND;
            end
            ST_WB_SEND: begin
                wb_valid_o = 1'b1;
                wb_line_o  = line;
                wb_data_o  = {wb_h1_q, wb_h0_q};
                if (wb_ready_i) begin
                    state_d = ST_IDLE;
                end
            end
            ST_RSP: begin
                rsp_valid_o      = 1'b1;
                rsp_channel_id_o = chan_q;
                rsp_rob_num_o    = rob_q;
                rsp_is_write_o   = (op_q == OP_WRITE);
                rsp_data_o       = rsp_data_q;
                if (rsp_ready_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule
